serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Digit-serial N-bit subtractor computing a - b - borrow_in, processing D bits per clock cycle.
- Serves as the multi-cycle, handshaked counterpart to the combinational adders in the same library. It is used in CGRA tiles where area matters more than latency.
- Upstream and downstream are valid/ready streams, and there is one operation in flight at a time.

Parameters:
- N, 8, operand and result width in bits; must be at least 2.
- D, 1, digit width in bits processed per cycle; must divide N. Elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and borrow_in are valid
- in_ready  output  1  block can accept an operation
- a  input  N  minuend (unsigned or two's complement)
- b  input  N  subtrahend
- b_in  input  1  borrow input
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- diff  output  N  (a - b - b_in) mod 2^N
- b_out  output  1  borrow out of the MSB

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, diff=0, b_out=0, digit counter=0, internal shift registers=0.
- in_ready is 0 while rst is high. After reset it equals (state==IDLE).
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready, latch a, b, and borrow register = b_in; set counter=0; go to BUSY.
- BUSY:
  - Each cycle, take the D LSBs of the a and b shift registers.
  - Compute the digit as a_d + ~b_d + ~borrow as a (D+1)-bit sum. The digit result is the low D bits; new borrow = ~sum[D].
  - Shift the digit into the MSB end of the result register, shift the operand registers right by D, and increment the counter.
  - When counter reaches N/D-1, go to DONE on the next edge.
- DONE:
  - out_valid=1. diff and the final borrow (b_out) are registered and held stable.
  - When out_ready is high, go to IDLE at that edge.
- Latency: N/D BUSY cycles. out_valid rises N/D cycles after the accepting edge (exactly 8 cycles for defaults).
- Throughput: one operation per N/D+2 cycles minimum. There is no overlap.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- in_valid held high while not IDLE: ignored. Operands are not re-sampled.
- Operand inputs changing during BUSY have no effect on the result.
- out_ready high when out_valid=0: ignored.
- diff and b_out stay at the last result after DONE→IDLE until the next result lands. out_valid=0 qualifies them.
- Boundary cases:
  - a=b with b_in=0 gives diff=0, b_out=0.
  - a=0, b=0, b_in=1 gives diff=all ones, b_out=1.
  - D=N gives a single BUSY cycle.
- Reset mid-operation: asserting rst in BUSY or DONE aborts immediately. Outputs return to reset values, with no spurious out_valid.
- Definition: b_out=1 iff a < b + b_in (unsigned compare at N+1 bits).

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the signed overflow flag.
  - ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]).
  - Registered with diff; reset 0; valid when out_valid=1.
  - Requires a latched copy of the a and b MSBs.
- Undefined: no ovf port and no extra flops. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Counter width: clog2(N/D), minimum 1.
- One natural sub-module: digit_subtractor.
  - Combinational D-bit cell with inputs a_d, b_d, bor_i and outputs d_d, bor_o.
  - Internally a chain of D 1-bit full-subtractor stages built as full adders with inverted b and borrow.
- Top level holds the FSM, counter, shift registers and handshake.

Test Plan:
- N=8, D=1: a=0x35, b=0x12, b_in=0 -> diff=0x23, b_out=0; out_valid exactly 8 cycles after accept.
- a=0x00, b=0x00, b_in=1 -> diff=0xFF, b_out=1. Also a=0x10, b=0x20 -> diff=0xF0, b_out=1.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, diff and b_out stable; in_ready=0; a second in_valid is not accepted until after the out_ready handshake.
- Assert rst 3 cycles into BUSY -> out_valid=0 and diff=0 immediately; the next operation a=0x80, b=0x01 gives diff=0x7F, b_out=0.
- N=8, D=4 and D=8 with 1000 random back-to-back ops -> all match the reference model mod 2^8; latency is 2 and 1 BUSY cycles respectively.
- With SERIAL_SUBTRACTOR_OVF_EN: a=0x80, b=0x01 -> ovf=1. a=0x7F, b=0xFF -> ovf=1. a=0x05, b=0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding and
// the digit-counter width helper.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of the digit counter: clog2(n/d), never narrower than one bit.
   function automatic int cnt_width(input int n, input int d);
      int w;
      w = $clog2(n / d);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/serial_subtractor_digit_subtractor.sv
// Combinational D-bit subtractor cell: a chain of full adders fed with the
// inverted subtrahend and inverted borrow, so carry == ~borrow throughout.
module digit_subtractor #(
   parameter int D = 1
) (
   input  logic [D-1:0] a_d,
   input  logic [D-1:0] b_d,
   input  logic         bor_i,
   output logic [D-1:0] d_d,
   output logic         bor_o
);

   logic carry;

   // NOTE: every output of a combinational block is assigned before any
   // conditional or loop so no path can leave it unassigned and infer a latch.
   always_comb begin
      d_d   = '0;
      carry = ~bor_i;
      for (int i = 0; i < D; i++) begin
         d_d[i] = a_d[i] ^ ~b_d[i] ^ carry;
         carry  = (a_d[i] & ~b_d[i]) | ((a_d[i] ^ ~b_d[i]) & carry);
      end
      bor_o = ~carry;
   end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial N-bit subtractor (a - b - b_in) with valid/ready handshakes,
// D bits per cycle. Define SERIAL_SUBTRACTOR_OVF_EN to add the signed ovf output.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int N = 8,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         b_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] diff,
   output logic         b_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int              DIGITS = N / D;
   localparam int              CW     = cnt_width(N, D);
   localparam logic [CW-1:0]   LAST   = CW'(DIGITS - 1);

   if (N < 2) begin : g_n_check
      $error("serial_subtractor: N must be at least 2");
   end
   if (D < 1 || (N % D) != 0) begin : g_d_check
      $error("serial_subtractor: D must divide N");
   end

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [N-1:0]  res_q, res_d;
   logic          bor_q, bor_d;
   logic [N-1:0]  diff_q, diff_d;
   logic          b_out_q, b_out_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic          a_msb_q, a_msb_d;
   logic          b_msb_q, b_msb_d;
   logic          ovf_q, ovf_d;
`endif

   logic [D-1:0]   dig_diff;
   logic           dig_bor;
   logic [N+D-1:0] res_cat;
   logic           accept;
   logic           last_digit;

   digit_subtractor #(.D(D)) u_digit (
      .a_d   (a_q[D-1:0]),
      .b_d   (b_q[D-1:0]),
      .bor_i (bor_q),
      .d_d   (dig_diff),
      .bor_o (dig_bor)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its pre-edge inputs regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)        state_d = BUSY;
         BUSY:    if (cnt_q == LAST)   state_d = DONE;
         DONE:    if (out_ready)       state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   // Handshake outputs decode registered state only; in_ready is forced low in reset.
   always_comb begin
      in_ready  = !rst && (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   assign accept     = in_valid && in_ready;
   assign last_digit = (state_q == BUSY) && (cnt_q == LAST);

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      bor_d   = bor_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      b_out_d = b_out_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      ovf_d   = ovf_q;
`endif
      res_cat = {dig_diff, res_q};
      if (accept) begin
         a_d   = a;
         b_d   = b;
         bor_d = b_in;
         cnt_d = '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         a_msb_d = a[N-1];
         b_msb_d = b[N-1];
`endif
      end else if (state_q == BUSY) begin
         a_d   = a_q >> D;
         b_d   = b_q >> D;
         res_d = res_cat[N+D-1:D];
         bor_d = dig_bor;
         cnt_d = cnt_q + CW'(1);
         // The visible result only changes when the final digit lands.
         if (last_digit) begin
            diff_d  = res_cat[N+D-1:D];
            b_out_d = dig_bor;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_d   = (a_msb_q != b_msb_q) && (dig_diff[D-1] != a_msb_q);
`endif
         end
      end
   end

   // NOTE: the shift registers are plain flops, so they are cleared in reset
   // like everything else; an abort leaves no stale operand or result behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         bor_q   <= 1'b0;
         diff_q  <= '0;
         b_out_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         bor_q   <= bor_d;
         diff_q  <= diff_d;
         b_out_q <= b_out_d;
      end
   end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

   assign diff  = diff_q;
   assign b_out = b_out_q;

endmodule
